// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes,
// SR/Cause field positions and the packed register views.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_TI    = 30;
    localparam int CAUSE_BD    = 31;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] EPC_MASK_DEF   = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] pack_sr(input sr_t s);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = s.im;
        w[SR_EXL] = s.exl;
        w[SR_IE] = s.ie;
        return w;
    endfunction

    // TI lives in the timer, so it is merged in at read time.
    function automatic logic [31:0] pack_cause(input cause_t c,
                                               input logic ti);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD] = c.bd;
        w[CAUSE_TI] = ti;
        w[CAUSE_IP_HI:CAUSE_IP_LO] = c.ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO] = c.exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the timer-interrupt flag TI.
// Only instantiated when CP0_COUNT_EN is defined.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic wr_count;
    logic wr_compare;

    assign wr_count   = wr && (addr == REG_COUNT);
    assign wr_compare = wr && (addr == REG_COMPARE);

    // Free-running counter; TI latches on match, cleared by a Compare write.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count <= wr_count ? wdata : count + 32'd1;
            if (wr_compare) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC, interrupt and exception request.
// Define CP0_COUNT_EN to add Count(9)/Compare(11) and the TI source.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] EPC_MASK   = EPC_MASK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    sr_t         sr;
    cause_t      cause;
    logic [31:0] epc;

    logic        ti;
    logic [31:0] count;
    logic [31:0] compare;

    logic [5:0]  int_lines;
    logic        int_req;
    logic        exc_req;
    logic        wr;
    logic [31:0] victim;

    // An mtc0 in the same cycle as req is flushed, so its write is dropped.
    assign wr = en && !req;

`ifdef CP0_COUNT_EN
    cp0_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .addr    (cp0_addr),
        .wdata   (cp0_in),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );
`else
    assign ti      = 1'b0;
    assign count   = '0;
    assign compare = '0;
`endif

    assign int_lines = {hw_int[5] | ti, hw_int[4:0]};
    assign int_req   = !sr.exl && sr.ie && (|(sr.im & int_lines));
    assign exc_req   = !sr.exl && (exc_code_in != 5'd0);
    assign req       = int_req || exc_req;

    assign victim = bd_in ? (vpc - 32'd4) : vpc;

    // Status: exception entry sets EXL, then mtc0, then eret clears EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (req) begin
            sr.exl <= 1'b1;
        end else if (wr && (cp0_addr == REG_SR)) begin
            sr.im  <= cp0_in[SR_IM_HI:SR_IM_LO];
            sr.exl <= cp0_in[SR_EXL];
            sr.ie  <= cp0_in[SR_IE];
        end else if (exl_clr) begin
            sr.exl <= 1'b0;
        end
    end

    // Cause: IP tracks the pins every cycle; BD/ExcCode captured on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause <= '0;
        end else begin
            cause.ip <= hw_int;
            if (req) begin
                cause.bd  <= bd_in;
                cause.exc <= int_req ? 5'(EXC_INT) : exc_code_in;
            end
        end
    end

    // EPC: victim PC on entry, otherwise mtc0 data; always word-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc <= '0;
        end else if (req) begin
            epc <= victim & EPC_MASK;
        end else if (wr && (cp0_addr == REG_EPC)) begin
            epc <= cp0_in & EPC_MASK;
        end
    end

    // mfc0 read mux; no bypass of a same-cycle mtc0.
    always_comb begin
        cp0_out = '0;
        case (cp0_addr)
            REG_SR:      cp0_out = pack_sr(sr);
            REG_CAUSE:   cp0_out = pack_cause(cause, ti);
            REG_EPC:     cp0_out = epc;
            REG_COUNT:   cp0_out = count;
            REG_COMPARE: cp0_out = compare;
            default:     cp0_out = '0;
        endcase
    end

    // eret right behind an mtc0 EPC sees the new value.
    assign epc_out = (en && (cp0_addr == REG_EPC) && !req)
                   ? (cp0_in & EPC_MASK) : epc;

    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus
// randomized traffic against a behavioural CP0 model.
module tb_cp0_unit;

`ifdef CP0_COUNT_EN
    localparam bit HAS_COUNT = 1'b1;
`else
    localparam bit HAS_COUNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_in      (cp0_in),
        .cp0_out     (cp0_out),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .exl_clr     (exl_clr),
        .req         (req),
        .epc_out     (epc_out),
        .handler_pc  (handler_pc)
    );

    // Reference model state, kept as plain 32-bit numbers.
    logic [31:0] m_im, m_exl, m_ie, m_bd, m_ip, m_exc, m_epc;
    logic [31:0] m_count, m_compare, m_ti;

    task automatic model_reset();
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = 0;
        m_exc = 0; m_epc = 0; m_count = 0; m_compare = 0; m_ti = 0;
    endtask

    function automatic bit m_int_req();
        logic [31:0] lines;
        lines = 32'(hw_int) | (m_ti << 5);
        return (m_exl == 0) && (m_ie != 0) && ((m_im & lines) != 0);
    endfunction

    function automatic bit m_req();
        return m_int_req() || ((m_exl == 0) && (exc_code_in != 0));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd12: return (m_im << 10) | (m_exl << 1) | m_ie;
            5'd13: return (m_bd << 31) | (m_ti << 30) | (m_ip << 10)
                          | (m_exc << 2);
            5'd14: return m_epc;
            5'd9:  return HAS_COUNT ? m_count : 32'd0;
            5'd11: return HAS_COUNT ? m_compare : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_epc_out();
        if (en && cp0_addr == 5'd14 && !m_req())
            return cp0_in & 32'hFFFF_FFFC;
        return m_epc;
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit r, ir, w;
        logic [31:0] n_count, n_compare, n_ti;
        ir = m_int_req();
        r = m_req();
        w = en && !r;
        n_count = (w && cp0_addr == 5'd9) ? cp0_in : m_count + 32'd1;
        n_compare = (w && cp0_addr == 5'd11) ? cp0_in : m_compare;
        if (w && cp0_addr == 5'd11) n_ti = 0;
        else if (m_count == m_compare) n_ti = 1;
        else n_ti = m_ti;
        if (HAS_COUNT) begin
            m_count = n_count; m_compare = n_compare; m_ti = n_ti;
        end
        m_ip = 32'(hw_int);
        if (r) begin
            m_exl = 1;
            m_bd = 32'(bd_in);
            m_exc = ir ? 0 : 32'(exc_code_in);
            m_epc = (bd_in ? vpc - 4 : vpc) & 32'hFFFF_FFFC;
        end else begin
            if (en && cp0_addr == 5'd12) begin
                m_im = (cp0_in >> 10) & 32'h3F;
                m_exl = (cp0_in >> 1) & 32'h1;
                m_ie = cp0_in & 32'h1;
            end else if (exl_clr) begin
                m_exl = 0;
            end
            if (en && cp0_addr == 5'd14) m_epc = cp0_in & 32'hFFFF_FFFC;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; cp0_addr = 0; cp0_in = 0; bd_in = 0;
        exc_code_in = 0; exl_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        hw_int = 0; vpc = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 12; i <= 14; i++) begin
            cp0_addr = 5'(i);
            #1;
            checks++;
            if (cp0_out !== 32'd0) begin
                failures++;
                $display("FAIL reset_read idx=%0d got=%h want=0", i, cp0_out);
            end
        end
        checks++;
        if (req !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got=%b want=0", req);
        end
        checks++;
        if (epc_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_epc_out got=%h want=0", epc_out);
        end
        checks++;
        if (handler_pc !== 32'h0000_4180) begin
            failures++;
            $display("FAIL handler_pc got=%h want=00004180", handler_pc);
        end
`ifdef CP0_COUNT_EN
        en = 1; cp0_addr = 5'd11; cp0_in = 32'hFFFF_FFFF;
        @(negedge clk);
        tick();
        idle();
`endif
    endtask

    task automatic test_int_entry();
        en = 1; cp0_addr = 5'd12; cp0_in = 32'h0000_0401;
        hw_int = 6'b000001;
        @(negedge clk);
        tick();
        idle();
        vpc = 32'h3010;
        @(negedge clk);
        checks++;
        if (req !== 1'b1) begin
            failures++;
            $display("FAIL int_req got=%b want=1", req);
        end
        tick();
        hw_int = 0;
        cp0_addr = 5'd14; #1;
        checks++;
        if (cp0_out !== 32'h3010) begin
            failures++;
            $display("FAIL int_epc got=%h want=00003010", cp0_out);
        end
        cp0_addr = 5'd13; #1;
        checks++;
        if (cp0_out !== 32'h0000_0400) begin
            failures++;
            $display("FAIL int_cause got=%h want=00000400", cp0_out);
        end
        cp0_addr = 5'd12; #1;
        checks++;
        if (cp0_out !== 32'h0000_0403) begin
            failures++;
            $display("FAIL int_sr got=%h want=00000403", cp0_out);
        end
        checks++;
        if (req !== 1'b0) begin
            failures++;
            $display("FAIL int_req_after got=%b want=0", req);
        end
    endtask

    task automatic test_exc_bd();
        en = 1; cp0_addr = 5'd12; cp0_in = 32'h0; hw_int = 0;
        @(negedge clk);
        tick();
        idle();
        exc_code_in = 5'd12; bd_in = 1; vpc = 32'h3024;
        @(negedge clk);
        checks++;
        if (req !== 1'b1) begin
            failures++;
            $display("FAIL exc_req got=%b want=1", req);
        end
        tick();
        idle();
        cp0_addr = 5'd14; #1;
        checks++;
        if (cp0_out !== 32'h3020) begin
            failures++;
            $display("FAIL exc_epc got=%h want=00003020", cp0_out);
        end
        cp0_addr = 5'd13; #1;
        checks++;
        if (cp0_out !== 32'h8000_0030) begin
            failures++;
            $display("FAIL exc_cause got=%h want=80000030", cp0_out);
        end
    endtask

    task automatic test_eret_repend();
        hw_int = 6'b000001;
        en = 1; cp0_addr = 5'd12; cp0_in = 32'h0000_0403;
        @(negedge clk);
        checks++;
        if (req !== 1'b0) begin
            failures++;
            $display("FAIL exl_masks_req got=%b want=0", req);
        end
        tick();
        idle();
        exl_clr = 1;
        @(negedge clk);
        tick();
        idle();
        cp0_addr = 5'd12; vpc = 32'h3100;
        @(negedge clk);
        checks++;
        if (cp0_out !== 32'h0000_0401) begin
            failures++;
            $display("FAIL eret_sr got=%h want=00000401", cp0_out);
        end
        checks++;
        if (req !== 1'b1) begin
            failures++;
            $display("FAIL eret_rereq got=%b want=1", req);
        end
        tick();
        hw_int = 0;
        #1;
        checks++;
        if (cp0_out !== 32'h0000_0403) begin
            failures++;
            $display("FAIL reentry_sr got=%h want=00000403", cp0_out);
        end
    endtask

    task automatic test_mtc0_vs_req();
        exl_clr = 1;
        @(negedge clk);
        tick();
        idle();
        en = 1; cp0_addr = 5'd14; cp0_in = 32'h5000;
        exc_code_in = 5'd8; vpc = 32'h3040;
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || epc_out !== 32'h3100) begin
            failures++;
            $display("FAIL req_vs_mtc0 req=%b epc_out=%h want req=1 epc_out=00003100",
                     req, epc_out);
        end
        tick();
        idle();
        cp0_addr = 5'd14; #1;
        checks++;
        if (cp0_out !== 32'h3040) begin
            failures++;
            $display("FAIL dropped_mtc0_epc got=%h want=00003040", cp0_out);
        end
        exl_clr = 1;
        @(negedge clk);
        tick();
        idle();
        en = 1; cp0_addr = 5'd14; cp0_in = 32'h5002;
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || epc_out !== 32'h5000) begin
            failures++;
            $display("FAIL epc_bypass req=%b epc_out=%h want req=0 epc_out=00005000",
                     req, epc_out);
        end
        tick();
        idle();
        cp0_addr = 5'd14; #1;
        checks++;
        if (cp0_out !== 32'h5000) begin
            failures++;
            $display("FAIL mtc0_epc_masked got=%h want=00005000", cp0_out);
        end
    endtask

    task automatic test_random();
        logic [4:0] addrs [7];
        logic [4:0] codes [6];
        logic [31:0] want;
        addrs = '{5'd9, 5'd11, 5'd12, 5'd12, 5'd13, 5'd14, 5'd0};
        codes = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd31};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(3) == 0);
            cp0_addr = ($urandom_range(7) == 0) ? 5'($urandom)
                       : addrs[$urandom_range(6)];
            cp0_in = $urandom;
            vpc = $urandom;
            bd_in = 1'($urandom);
            exc_code_in = ($urandom_range(5) == 0)
                          ? codes[$urandom_range(5)] : 5'd0;
            hw_int = ($urandom_range(2) == 0) ? 6'($urandom) : 6'd0;
            exl_clr = !en && ($urandom_range(4) == 0);
            @(negedge clk);
            checks++;
            if (req !== m_req()) begin
                failures++;
                $display("FAIL rand_req cyc=%0d got=%b want=%b", c, req, m_req());
            end
            want = m_read(cp0_addr);
            checks++;
            if (cp0_out !== want) begin
                failures++;
                $display("FAIL rand_read cyc=%0d idx=%0d got=%h want=%h",
                         c, cp0_addr, cp0_out, want);
            end
            want = m_epc_out();
            checks++;
            if (epc_out !== want) begin
                failures++;
                $display("FAIL rand_epc_out cyc=%0d got=%h want=%h", c, epc_out, want);
            end
            tick();
        end
        idle();
        hw_int = 0;
    endtask

`ifdef CP0_COUNT_EN
    task automatic test_count();
        bit seen;
        do_reset();
        en = 1; cp0_addr = 5'd11; cp0_in = 32'd20;
        @(negedge clk);
        tick();
        en = 1; cp0_addr = 5'd12; cp0_in = 32'h0000_8001;
        @(negedge clk);
        tick();
        idle();
        cp0_addr = 5'd9;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (req === 1'b1) begin
                seen = 1;
                checks++;
                if (cp0_out !== 32'd21) begin
                    failures++;
                    $display("FAIL ti_req_count got=%0d want=21", cp0_out);
                end
            end else begin
                tick();
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL ti_req_timeout got=0 want=1");
        end
        tick();
        en = 1; cp0_addr = 5'd11; cp0_in = 32'd1000;
        @(negedge clk);
        tick();
        idle();
        exl_clr = 1;
        @(negedge clk);
        tick();
        idle();
        cp0_addr = 5'd13;
        @(negedge clk);
        checks++;
        if (cp0_out[30] !== 1'b0 || req !== 1'b0) begin
            failures++;
            $display("FAIL ti_clear ti=%b req=%b want ti=0 req=0", cp0_out[30], req);
        end
        tick();
    endtask
`endif

    initial begin
        reset = 1;
        idle();
        hw_int = 0;
        vpc = 0;
        model_reset();
        test_reset();
        test_int_entry();
        test_exc_bd();
        test_eret_repend();
        test_mtc0_vs_req();
        test_random();
`ifdef CP0_COUNT_EN
        test_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
